// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map, CTRL/STATUS layouts and sequencer state encoding for gpio_ctrl
package gpio_pkg;

  localparam logic [2:0] REG_OUT      = 3'd0;
  localparam logic [2:0] REG_SET      = 3'd1;
  localparam logic [2:0] REG_CLR      = 3'd2;
  localparam logic [2:0] REG_TGL      = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_PATTERN  = 3'd5;
  localparam logic [2:0] REG_CTRL     = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // CTRL: bit0 RUN, bits[2:1] LAST, bit3 ONESHOT
  typedef struct packed {
    logic       oneshot;
    logic [1:0] last;
    logic       run;
  } ctrl_t;

  // STATUS: bit0 BUSY, bits[2:1] IDX, bit3 DONE
  typedef struct packed {
    logic       done;
    logic [1:0] idx;
    logic       busy;
  } status_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    for (int b = 0; b < 4; b++) begin
      merge_bytes[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/gpio_prescaler.sv
// rtl/gpio_prescaler.sv - reloadable down-counter producing a one-cycle tick on reaching zero
module gpio_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] reload,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick = en && !load && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= reload;
    end else if (en) begin
      cnt_q <= tick ? reload : cnt_q - PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO output register with set/clear/toggle and optional pattern sequencer
// Sequencer, PRESCALE, PATTERN, CTRL and STATUS exist only when GPIO_PATTERN_EN is defined.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int PRESCALE_W = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [2:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [7:0]  gpio
);

  logic        accept;
  logic        wr;
  logic        cpu_out_wr;
  logic [7:0]  cpu_out_val;
  logic [7:0]  out_q;
  logic [31:0] rd_val;

  assign accept = sel && (we || re);
  assign wr     = sel && we;
  assign gpio   = out_q;

  always_comb begin
    cpu_out_wr  = wr && wmask[0] && (addr <= REG_TGL);
    cpu_out_val = wdata[7:0];
    case (addr[1:0])
      2'd1:    cpu_out_val = out_q | wdata[7:0];
      2'd2:    cpu_out_val = out_q & ~wdata[7:0];
      2'd3:    cpu_out_val = out_q ^ wdata[7:0];
      default: cpu_out_val = wdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      rdata <= (accept && re) ? rd_val : '0;
    end
  end

`ifdef GPIO_PATTERN_EN
  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           pattern_q;
  ctrl_t                 ctrl_q;
  ctrl_t                 ctrl_new;
  status_t               status;
  logic [1:0]            state_q;
  logic [1:0]            idx_q;
  logic [1:0]            idx_next;
  logic                  done_q;
  logic                  running;
  logic                  ctrl_wr;
  logic                  start;
  logic                  stop;
  logic                  step;
  logic                  finish;
  logic                  tick;

  assign running  = (state_q == ST_RUN);
  assign ctrl_new = ctrl_t'(wdata[3:0]);
  assign ctrl_wr  = wr && wmask[0] && (addr == REG_CTRL);
  assign start    = ctrl_wr && ctrl_new.run;
  assign stop     = ctrl_wr && !ctrl_new.run && running;
  // A CTRL write landing on a tick edge wins over stepping.
  assign step     = running && tick && !ctrl_wr;
  assign finish   = step && ctrl_q.oneshot && (idx_q == ctrl_q.last);
  assign idx_next = (idx_q >= ctrl_q.last) ? 2'd0 : idx_q + 2'd1;
  assign status   = status_t'{done_q, idx_q, running};

  gpio_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .load   (start),
    .en     (running),
    .reload (prescale_q),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prescale_q <= '0;
      pattern_q  <= '0;
      ctrl_q     <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      if (wr && addr == REG_PRESCALE)
        prescale_q <= PRESCALE_W'(merge_bytes(32'(prescale_q), wdata, wmask));
      if (wr && addr == REG_PATTERN)
        pattern_q <= merge_bytes(pattern_q, wdata, wmask);
      if (ctrl_wr)
        ctrl_q <= ctrl_new;
      else if (finish)
        ctrl_q.run <= 1'b0;
      if (start) begin
        state_q <= ST_RUN;
        idx_q   <= '0;
        done_q  <= 1'b0;
      end else if (stop) begin
        state_q <= ST_IDLE;
      end else if (finish) begin
        state_q <= ST_DONE;
        done_q  <= 1'b1;
      end else if (step) begin
        idx_q <= idx_next;
      end
    end
  end

  // CPU writes to OUT override the sequencer byte; the index still advances.
  always_ff @(posedge clk) begin
    if (!resetn)
      out_q <= '0;
    else if (cpu_out_wr)
      out_q <= cpu_out_val;
    else if (start)
      out_q <= pattern_q[7:0];
    else if (step && !finish)
      out_q <= pattern_q[{idx_next, 3'b000} +: 8];
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      REG_OUT:      rd_val = {24'h0, out_q};
      REG_PRESCALE: rd_val = 32'(prescale_q);
      REG_PATTERN:  rd_val = pattern_q;
      REG_CTRL:     rd_val = {28'h0, ctrl_q};
      REG_STATUS:   rd_val = {28'h0, status};
      default:      rd_val = '0;
    endcase
  end
`else
  logic [PRESCALE_W-1:0] unused_prescale_w;
  logic [27:0]           unused_wr_bits;

  assign unused_prescale_w = '0;
  assign unused_wr_bits    = {wdata[31:8], wmask[3:1], 1'b0};

  always_ff @(posedge clk) begin
    if (!resetn)
      out_q <= '0;
    else if (cpu_out_wr)
      out_q <= cpu_out_val;
  end

  always_comb begin
    rd_val = '0;
    if (addr == REG_OUT)
      rd_val = {24'h0, out_q};
  end
`endif

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - scoreboard bench for gpio_ctrl; sequencer scenarios compile under GPIO_PATTERN_EN
module tb_gpio_ctrl;

  localparam logic [2:0] A_OUT = 3'd0, A_SET = 3'd1, A_CLR = 3'd2, A_TGL = 3'd3;
  localparam logic [2:0] A_PRE = 3'd4, A_PAT = 3'd5, A_CTRL = 3'd6, A_STAT = 3'd7;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  gpio;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  gpio_ctrl #(.PRESCALE_W(24)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .wmask(wmask), .rdata(rdata), .ready(ready), .gpio(gpio)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d; wmask = m;
    cycle();
    sel = 1'b0; we = 1'b0; wmask = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic rdy);
    sel = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    cycle();
    sel = 1'b0; re = 1'b0;
    d = rdata;
    rdy = ready;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    resetn = 1'b0;
    repeat (3) cycle();
    tests_run++;
    if (gpio !== 8'h00) begin tests_failed++; $display("FAIL reset_gpio: got %02h want 00", gpio); end
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", ready); end
    tests_run++;
    if (rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %08h want 0", rdata); end
    resetn = 1'b1;
    cycle();
    sb_q.push_back(32'h0);
    bus_read(A_OUT, d, r);
    tests_run++;
    if (d !== sb_q.pop_front() || r !== 1'b1) begin
      tests_failed++; $display("FAIL reset_out_read: got %08h ready %b want 0 ready 1", d, r);
    end
  endtask

  task automatic test_out_ops();
    logic [2:0] ta[6] = '{A_OUT, A_SET, A_CLR, A_TGL, A_OUT, A_SET};
    logic [7:0] td[6] = '{8'hA5, 8'h0A, 8'h81, 8'hFF, 8'h00, 8'hFF};
    logic [3:0] tm[6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hE};
    logic [7:0] te[6] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1, 8'hD1, 8'hD1};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back({24'h0, te[i]});
      bus_write(ta[i], {4{td[i]}}, tm[i]);
      exp = sb_q.pop_front();
      tests_run++;
      if (gpio !== exp[7:0]) begin
        tests_failed++; $display("FAIL out_ops[%0d] gpio: got %02h want %02h", i, gpio, exp[7:0]);
      end
      tests_run++;
      if (ready !== 1'b1) begin tests_failed++; $display("FAIL out_ops[%0d] ready: got %b want 1", i, ready); end
    end
  endtask

  task automatic test_readback();
    logic [2:0]  ta[4] = '{A_OUT, A_SET, A_CLR, A_TGL};
    logic [31:0] te[4] = '{32'hD1, 32'h0, 32'h0, 32'h0};
    logic [31:0] d;
    logic        r;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(te[i]);
      bus_read(ta[i], d, r);
      tests_run++;
      if (d !== sb_q.pop_front() || r !== 1'b1) begin
        tests_failed++; $display("FAIL readback[%0d]: got %08h ready %b want %08h ready 1", i, d, r, te[i]);
      end
    end
    cycle();
    tests_run++;
    if (ready !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++; $display("FAIL ready_width: got ready %b rdata %08h want 0 0", ready, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = A_OUT; wdata = 32'h3C; wmask = 4'hF;
    sb_q.push_back(32'h3C);
    sb_q.push_back(32'h3C);
    cycle();
    we = 1'b0; re = 1'b1; wmask = '0;
    exp = sb_q.pop_front();
    tests_run++;
    if (ready !== 1'b1 || gpio !== exp[7:0]) begin
      tests_failed++; $display("FAIL b2b_write: got ready %b gpio %02h want 1 %02h", ready, gpio, exp[7:0]);
    end
    cycle();
    sel = 1'b0; re = 1'b0;
    exp = sb_q.pop_front();
    tests_run++;
    if (ready !== 1'b1 || rdata !== exp) begin
      tests_failed++; $display("FAIL b2b_read: got ready %b rdata %08h want 1 %08h", ready, rdata, exp);
    end
    cycle();
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got ready %b want 0", ready); end
  endtask

`ifdef GPIO_PATTERN_EN
  task automatic test_pattern_run();
    logic [31:0] d;
    logic        r;
    logic [31:0] exp;
    bus_write(A_PRE, 32'h00AABB02, 4'h1);
    bus_write(A_PAT, 32'h08040201, 4'hF);
    bus_read(A_PRE, d, r);
    tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("FAIL prescale_read: got %08h want 00000002", d); end
    bus_read(A_PAT, d, r);
    tests_run++;
    if (d !== 32'h08040201) begin tests_failed++; $display("FAIL pattern_read: got %08h want 08040201", d); end
    for (int i = 0; i < 13; i++) sb_q.push_back(32'(8'h01 << ((i / 3) % 4)));
    bus_write(A_CTRL, 32'h7, 4'hF);
    for (int i = 0; i < 13; i++) begin
      exp = sb_q.pop_front();
      tests_run++;
      if (gpio !== exp[7:0]) begin
        tests_failed++; $display("FAIL run_seq[%0d]: got %02h want %02h", i, gpio, exp[7:0]);
      end
      cycle();
    end
    bus_read(A_STAT, d, r);
    tests_run++;
    if ((d & 32'h9) !== 32'h1) begin tests_failed++; $display("FAIL run_busy: got %08h want BUSY=1 DONE=0", d); end
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_read(A_STAT, d, r);
    tests_run++;
    if ((d & 32'h1) !== 32'h0) begin tests_failed++; $display("FAIL stop_busy: got %08h want BUSY=0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        r;
    logic [31:0] exp;
    for (int i = 0; i < 12; i++) sb_q.push_back(32'(8'h01 << (i / 3)));
    for (int i = 0; i < 6; i++) sb_q.push_back(32'h08);
    bus_write(A_CTRL, 32'hF, 4'hF);
    for (int i = 0; i < 18; i++) begin
      exp = sb_q.pop_front();
      tests_run++;
      if (gpio !== exp[7:0]) begin
        tests_failed++; $display("FAIL oneshot_seq[%0d]: got %02h want %02h", i, gpio, exp[7:0]);
      end
      cycle();
    end
    bus_read(A_STAT, d, r);
    tests_run++;
    if (d !== 32'hE) begin tests_failed++; $display("FAIL oneshot_status: got %08h want 0000000e", d); end
    bus_read(A_CTRL, d, r);
    tests_run++;
    if (d !== 32'hE) begin tests_failed++; $display("FAIL oneshot_ctrl: got %08h want 0000000e", d); end
  endtask

  task automatic test_tick_collision();
    logic [31:0] d;
    logic        r;
    logic [7:0]  te[6] = '{8'h01, 8'h81, 8'h04, 8'h04, 8'h04, 8'h04};
    for (int i = 0; i < 6; i++) sb_q.push_back({24'h0, te[i]});
    bus_write(A_PRE, 32'h0, 4'hF);
    bus_write(A_CTRL, 32'h7, 4'hF);
    for (int i = 0; i < 6; i++) begin
      d = sb_q.pop_front();
      tests_run++;
      if (gpio !== d[7:0]) begin
        tests_failed++; $display("FAIL collide[%0d]: got %02h want %02h", i, gpio, d[7:0]);
      end
      case (i)
        0:       bus_write(A_SET, 32'h80, 4'h1);
        2:       bus_write(A_CTRL, 32'h0, 4'hF);
        default: cycle();
      endcase
    end
    bus_read(A_STAT, d, r);
    tests_run++;
    if (d !== 32'h4) begin tests_failed++; $display("FAIL collide_status: got %08h want 00000004", d); end
  endtask
`else
  task automatic test_unmapped();
    logic [31:0] d;
    logic        r;
    for (int a = 4; a < 8; a++) bus_write(3'(a), 32'hFFFFFFFF, 4'hF);
    for (int a = 4; a < 8; a++) begin
      sb_q.push_back(32'h0);
      bus_read(3'(a), d, r);
      tests_run++;
      if (d !== sb_q.pop_front() || r !== 1'b1) begin
        tests_failed++; $display("FAIL unmapped[%0d]: got %08h ready %b want 0 ready 1", a, d, r);
      end
    end
    tests_run++;
    if (gpio !== 8'h3C) begin tests_failed++; $display("FAIL unmapped_gpio: got %02h want 3c", gpio); end
  endtask
`endif

  task automatic test_reset_midrun();
    logic [31:0] d;
    logic        r;
`ifdef GPIO_PATTERN_EN
    bus_write(A_CTRL, 32'h7, 4'hF);
`else
    bus_write(A_OUT, 32'h5A, 4'hF);
`endif
    sel = 1'b1; re = 1'b1; addr = A_OUT;
    cycle();
    sel = 1'b0; re = 1'b0;
    resetn = 1'b0;
    cycle();
    tests_run++;
    if (gpio !== 8'h00 || ready !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++; $display("FAIL midrun_reset: got gpio %02h ready %b rdata %08h want 0 0 0", gpio, ready, rdata);
    end
    resetn = 1'b1;
    repeat (3) cycle();
    tests_run++;
    if (gpio !== 8'h00) begin tests_failed++; $display("FAIL post_reset_gpio: got %02h want 00", gpio); end
`ifdef GPIO_PATTERN_EN
    bus_read(A_STAT, d, r);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL post_reset_status: got %08h want 0", d); end
    bus_read(A_CTRL, d, r);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL post_reset_ctrl: got %08h want 0", d); end
    bus_read(A_PAT, d, r);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL post_reset_pattern: got %08h want 0", d); end
`endif
    bus_read(A_OUT, d, r);
    tests_run++;
    if (d !== 32'h0 || r !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_out: got %08h ready %b want 0 ready 1", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_out_ops();
    test_readback();
    test_back_to_back();
`ifdef GPIO_PATTERN_EN
    test_pattern_run();
    test_oneshot();
    test_tick_collision();
`else
    test_unmapped();
`endif
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
